// File: rtl/stall_ctrl_if.sv
// Pipeline-side view of the stall controller: stage instruction words in,
// pipeline-register/PC control out.
interface stall_ctrl_if;
  logic [31:0] D_IR;
  logic [31:0] E_IR;
  logic [31:0] M_IR;
  logic        PC_We;
  logic        D_We;
  logic        E_Rst;
  logic        Stall;
  logic        Busy;

  modport master (
    output D_IR, E_IR, M_IR,
    input  PC_We, D_We, E_Rst, Stall, Busy
  );

  modport slave (
    input  D_IR, E_IR, M_IR,
    output PC_We, D_We, E_Rst, Stall, Busy
  );
endinterface

// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: Tuse/Tnew data hazards
// plus a mult/div busy window, driving PC/FD enables and the D/E bubble clear.
module stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input logic         Clk,
  input logic         Rst,
  stall_ctrl_if.slave bus
);

  typedef struct packed {
    logic       use_rs;
    logic       use_rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       mdu_op;
  } src_t;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } dst_t;

  // Source-side decode of the D stage word: which registers are read and how soon.
  function automatic src_t src_decode(input logic [5:0] op, input logic [5:0] fn);
    src_t s;
    s = '0;
    case (op)
      6'h00: begin
        case (fn)
          6'h21, 6'h23: begin
            s.use_rs = 1'b1; s.use_rt = 1'b1; s.tuse_rs = 2'd1; s.tuse_rt = 2'd1;
          end
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            s.use_rs = 1'b1; s.use_rt = 1'b1; s.tuse_rs = 2'd1; s.tuse_rt = 2'd1;
            s.mdu_op = 1'b1;
          end
          6'h08: begin
            s.use_rs = 1'b1; s.tuse_rs = 2'd0;
          end
          6'h10, 6'h12: s.mdu_op = 1'b1;
          6'h11, 6'h13: begin
            s.use_rs = 1'b1; s.tuse_rs = 2'd1; s.mdu_op = 1'b1;
          end
          default: ;
        endcase
      end
      6'h0D, 6'h23: begin
        s.use_rs = 1'b1; s.tuse_rs = 2'd1;
      end
      6'h2B: begin
        s.use_rs = 1'b1; s.tuse_rs = 2'd1; s.use_rt = 1'b1; s.tuse_rt = 2'd2;
      end
      6'h04: begin
        s.use_rs = 1'b1; s.use_rt = 1'b1; s.tuse_rs = 2'd0; s.tuse_rt = 2'd0;
      end
      default: ;
    endcase
    return s;
  endfunction

  // Destination and remaining cycles until the result is forwardable, per stage.
  function automatic dst_t dst_decode(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic in_m);
    dst_t d;
    d = '0;
    case (op)
      6'h00: begin
        if (fn == 6'h21 || fn == 6'h23 || fn == 6'h10 || fn == 6'h12) begin
          d.dst  = rd;
          d.tnew = in_m ? 2'd0 : 2'd1;
        end
      end
      6'h0D, 6'h0F: begin
        d.dst  = rt;
        d.tnew = in_m ? 2'd0 : 2'd1;
      end
      6'h23: begin
        d.dst  = rt;
        d.tnew = in_m ? 2'd1 : 2'd2;
      end
      6'h03: begin
        d.dst  = 5'd31;
        d.tnew = 2'd0;
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic hazard(input src_t s, input logic [4:0] rs,
                                  input logic [4:0] rt, input dst_t d);
    return (d.dst != 5'd0) &&
           ((s.use_rs && rs == d.dst && s.tuse_rs < d.tnew) ||
            (s.use_rt && rt == d.dst && s.tuse_rt < d.tnew));
  endfunction

  logic [3:0] mdu_cnt;
  logic       e_mult;
  logic       e_div;
  logic       busy;
  logic       data_stall;
  logic       mdu_stall;
  logic       stall;
  src_t       d_src;
  dst_t       e_dst;
  dst_t       m_dst;
  logic       unused_bits;

  assign unused_bits = ^{bus.D_IR[15:6], bus.E_IR[25:21], bus.E_IR[10:6],
                         bus.M_IR[25:21], bus.M_IR[10:6]};

  assign e_mult = (bus.E_IR[31:26] == 6'h00) &&
                  (bus.E_IR[5:0] == 6'h18 || bus.E_IR[5:0] == 6'h19);
  assign e_div  = (bus.E_IR[31:26] == 6'h00) &&
                  (bus.E_IR[5:0] == 6'h1A || bus.E_IR[5:0] == 6'h1B);

  // Busy window starts counting once the mult/div has left E; a new one reloads.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mdu_cnt <= 4'd0;
    end else if (e_mult) begin
      mdu_cnt <= 4'(MULT_CYC);
    end else if (e_div) begin
      mdu_cnt <= 4'(DIV_CYC);
    end else if (mdu_cnt != 4'd0) begin
      mdu_cnt <= mdu_cnt - 4'd1;
    end
  end

  assign busy = (mdu_cnt != 4'd0);

  always_comb begin
    d_src      = src_decode(bus.D_IR[31:26], bus.D_IR[5:0]);
    e_dst      = dst_decode(bus.E_IR[31:26], bus.E_IR[5:0], bus.E_IR[20:16],
                            bus.E_IR[15:11], 1'b0);
    m_dst      = dst_decode(bus.M_IR[31:26], bus.M_IR[5:0], bus.M_IR[20:16],
                            bus.M_IR[15:11], 1'b1);
    data_stall = hazard(d_src, bus.D_IR[25:21], bus.D_IR[20:16], e_dst) ||
                 hazard(d_src, bus.D_IR[25:21], bus.D_IR[20:16], m_dst);
    mdu_stall  = d_src.mdu_op && (busy || e_mult || e_div);
    stall      = (data_stall || mdu_stall) && !Rst;
  end

  assign bus.Stall = stall;
  assign bus.Busy  = busy;
  assign bus.PC_We = !stall;
  assign bus.D_We  = !stall;
  assign bus.E_Rst = stall || Rst;

endmodule
